// File: rtl/calc_pkg.sv
// Shared operation codes for the calculator operand stack, its input
// decoder and the ALU control.
package calc_pkg;

   typedef enum logic [2:0] {
      OP_NOP        = 3'd0,
      OP_PUSH       = 3'd1,
      OP_POP        = 3'd2,
      OP_WRITE      = 3'd3,
      OP_PUSH_VALUE = 3'd4,
      OP_REDUCE     = 3'd5,
      OP_SWAP       = 3'd6,
      OP_CLEAR      = 3'd7
   } stack_op_t;

   localparam int OP_BITS = 3;

endpackage

// File: rtl/stack_spill_ram.sv
// Spill storage for stack entries below top and next. Entry 0 is the
// deepest entry. Writes land on the clock edge; reads are asynchronous so
// the stack can refill its next register in the same cycle as a removal.
module stack_spill_ram #(
   parameter int WIDTH   = 32,
   parameter int ENTRIES = 62,
   parameter int AW      = 6
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [ENTRIES];

   // Store the entry pushed down from the next register.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/calc_stack.sv
// Operand stack for the calculator datapath. The two entries the ALU needs
// live in registers; deeper entries spill to a small RAM addressed by count.
// The stack never becomes empty: an idle calculator has count 1, top 0.
module calc_stack
   import calc_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 64,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] next,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow,
   output logic             error
);

   localparam int ENTRIES = DEPTH - 2;
   localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   stack_op_t        op_e;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] top_q, top_d;
   logic [WIDTH-1:0] next_q, next_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] refill;

   assign op_e    = stack_op_t'(op);
   assign wr_addr = AW'(count_q - CW'(2));
   assign rd_addr = AW'(count_q - CW'(3));

   // The entry that becomes next after removing one: spilled data when the
   // RAM holds something, otherwise the zero of a single-entry stack.
   assign refill  = (count_q >= CW'(3)) ? rd_data : '0;

   stack_spill_ram #(
      .WIDTH   (WIDTH),
      .ENTRIES (ENTRIES),
      .AW      (AW)
   ) u_spill (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (next_q),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Decode the operation into the next stack state; a failing op only
   // raises its flag, and a raised flag freezes everything except CLEAR.
   always_comb begin
      count_d = count_q;
      top_d   = top_q;
      next_d  = next_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      if (op_valid) begin
         if (op_e == OP_CLEAR) begin
            count_d = CW'(1);
            top_d   = '0;
            next_d  = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
         end else if (!(ovf_q || unf_q)) begin
            case (op_e)
               OP_PUSH, OP_PUSH_VALUE: begin
                  if (count_q == CW'(DEPTH)) begin
                     ovf_d = 1'b1;
                  end else begin
                     count_d = count_q + CW'(1);
                     top_d   = (op_e == OP_PUSH_VALUE) ? value : '0;
                     next_d  = top_q;
                     wr_en   = (count_q >= CW'(2));
                  end
               end
               OP_POP: begin
                  if (count_q == CW'(1)) begin
                     unf_d = 1'b1;
                  end else begin
                     count_d = count_q - CW'(1);
                     top_d   = next_q;
                     next_d  = refill;
                  end
               end
               OP_WRITE: begin
                  top_d = value;
               end
               OP_REDUCE: begin
                  if (count_q < CW'(2)) begin
                     unf_d = 1'b1;
                  end else begin
                     count_d = count_q - CW'(1);
                     top_d   = value;
                     next_d  = refill;
                  end
               end
               OP_SWAP: begin
                  if (count_q < CW'(2)) begin
                     unf_d = 1'b1;
                  end else begin
                     top_d  = next_q;
                     next_d = top_q;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Hold the registered top/next pair, entry count and sticky flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= CW'(1);
         top_q   <= '0;
         next_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         top_q   <= top_d;
         next_q  <= next_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign top       = top_q;
   assign next      = (count_q == CW'(1)) ? '0 : next_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign error     = ovf_q | unf_q;

endmodule

// File: tb/tb_calc_stack.sv
// Directed bench for calc_stack: a default 32x64 instance and a small 8x4
// instance for the overflow boundary, sharing clock and reset.
module tb_calc_stack;
   import calc_pkg::*;

   logic        clock;
   logic        reset_n;

   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] value;
   logic [31:0] top;
   logic [31:0] next;
   logic [6:0]  count;
   logic        overflow;
   logic        underflow;
   logic        error;

   logic        op_valid_s;
   logic [2:0]  op_s;
   logic [7:0]  value_s;
   logic [7:0]  top_s;
   logic [7:0]  next_s;
   logic [2:0]  count_s;
   logic        overflow_s;
   logic        underflow_s;
   logic        error_s;

   int compared;
   int mismatched;

   calc_stack dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .op_valid  (op_valid),
      .op        (op),
      .value     (value),
      .top       (top),
      .next      (next),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .error     (error)
   );

   calc_stack #(.WIDTH(8), .DEPTH(4)) dut_small (
      .clock     (clock),
      .reset_n   (reset_n),
      .op_valid  (op_valid_s),
      .op        (op_s),
      .value     (value_s),
      .top       (top_s),
      .next      (next_s),
      .count     (count_s),
      .overflow  (overflow_s),
      .underflow (underflow_s),
      .error     (error_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Apply one op to the large stack across a single rising edge; returns
   // at the following falling edge, where outputs are sampled.
   task automatic do_op(input logic [2:0] o, input logic [31:0] v);
      @(negedge clock);
      op_valid = 1'b1;
      op       = o;
      value    = v;
      @(negedge clock);
      op_valid = 1'b0;
   endtask

   task automatic do_op_s(input logic [2:0] o, input logic [7:0] v);
      @(negedge clock);
      op_valid_s = 1'b1;
      op_s       = o;
      value_s    = v;
      @(negedge clock);
      op_valid_s = 1'b0;
   endtask

   task automatic test_reset();
      #7;
      compared++;
      if ({count, top, next, overflow, underflow, error} !== {7'd1, 32'd0, 32'd0, 3'b000}) begin
         $display("[TB] FAIL reset_async count=%0d top=%0h next=%0h flags=%b%b%b want 1/0/0/000",
                  count, top, next, overflow, underflow, error);
         mismatched++;
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      compared++;
      if ({count_s, top_s, next_s, error_s} !== {3'd1, 8'd0, 8'd0, 1'b0}) begin
         $display("[TB] FAIL reset_small count=%0d top=%0h next=%0h error=%b want 1/0/0/0",
                  count_s, top_s, next_s, error_s);
         mismatched++;
      end
   endtask

   task automatic test_reduce();
      do_op(OP_PUSH_VALUE, 32'd5);
      compared++;
      if ({count, top, next} !== {7'd2, 32'd5, 32'd0}) begin
         $display("[TB] FAIL push5 count=%0d top=%0h next=%0h want 2/5/0", count, top, next);
         mismatched++;
      end
      do_op(OP_PUSH_VALUE, 32'd7);
      compared++;
      if ({count, top, next} !== {7'd3, 32'd7, 32'd5}) begin
         $display("[TB] FAIL push7 count=%0d top=%0h next=%0h want 3/7/5", count, top, next);
         mismatched++;
      end
      do_op(OP_REDUCE, 32'd12);
      compared++;
      if ({count, top, next} !== {7'd2, 32'd12, 32'd0}) begin
         $display("[TB] FAIL reduce12 count=%0d top=%0h next=%0h want 2/c/0", count, top, next);
         mismatched++;
      end
      do_op(OP_REDUCE, 32'd99);
      compared++;
      if ({count, top, next, error} !== {7'd1, 32'd99, 32'd0, 1'b0}) begin
         $display("[TB] FAIL reduce_at2 count=%0d top=%0h next=%0h err=%b want 1/63/0/0",
                  count, top, next, error);
         mismatched++;
      end
   endtask

   task automatic test_overflow();
      do_op_s(OP_PUSH_VALUE, 8'd1);
      do_op_s(OP_PUSH_VALUE, 8'd2);
      do_op_s(OP_PUSH_VALUE, 8'd3);
      compared++;
      if ({count_s, top_s, next_s, error_s} !== {3'd4, 8'd3, 8'd2, 1'b0}) begin
         $display("[TB] FAIL fill_small count=%0d top=%0h next=%0h err=%b want 4/3/2/0",
                  count_s, top_s, next_s, error_s);
         mismatched++;
      end
      do_op_s(OP_PUSH_VALUE, 8'd4);
      compared++;
      if ({count_s, top_s, next_s, overflow_s, underflow_s, error_s} !== {3'd4, 8'd3, 8'd2, 3'b101}) begin
         $display("[TB] FAIL overflow count=%0d top=%0h next=%0h flags=%b%b%b want 4/3/2/101",
                  count_s, top_s, next_s, overflow_s, underflow_s, error_s);
         mismatched++;
      end
      do_op_s(OP_POP, 8'd0);
      compared++;
      if ({count_s, top_s, next_s, overflow_s, error_s} !== {3'd4, 8'd3, 8'd2, 2'b11}) begin
         $display("[TB] FAIL pop_blocked count=%0d top=%0h next=%0h ovf=%b err=%b want 4/3/2/1/1",
                  count_s, top_s, next_s, overflow_s, error_s);
         mismatched++;
      end
      do_op_s(OP_CLEAR, 8'd0);
      compared++;
      if ({count_s, top_s, next_s, overflow_s, underflow_s, error_s} !== {3'd1, 8'd0, 8'd0, 3'b000}) begin
         $display("[TB] FAIL clear_small count=%0d top=%0h next=%0h flags=%b%b%b want 1/0/0/000",
                  count_s, top_s, next_s, overflow_s, underflow_s, error_s);
         mismatched++;
      end
   endtask

   task automatic test_underflow();
      do_op(OP_CLEAR, 32'd0);
      do_op(OP_POP, 32'd0);
      compared++;
      if ({count, top, overflow, underflow, error} !== {7'd1, 32'd0, 3'b011}) begin
         $display("[TB] FAIL pop_at1 count=%0d top=%0h flags=%b%b%b want 1/0/011",
                  count, top, overflow, underflow, error);
         mismatched++;
      end
      do_op(OP_CLEAR, 32'd0);
      do_op(OP_WRITE, 32'h55);
      do_op(OP_SWAP, 32'd0);
      compared++;
      if ({count, top, next, underflow, error} !== {7'd1, 32'h55, 32'd0, 2'b11}) begin
         $display("[TB] FAIL swap_at1 count=%0d top=%0h next=%0h unf=%b err=%b want 1/55/0/1/1",
                  count, top, next, underflow, error);
         mismatched++;
      end
      do_op(OP_WRITE, 32'h66);
      compared++;
      if (top !== 32'h55) begin
         $display("[TB] FAIL write_blocked top=%0h want 55", top);
         mismatched++;
      end
      do_op(OP_CLEAR, 32'd0);
   endtask

   task automatic test_spill();
      do_op(OP_PUSH_VALUE, 32'd10);
      do_op(OP_PUSH_VALUE, 32'd20);
      do_op(OP_PUSH_VALUE, 32'd30);
      do_op(OP_PUSH_VALUE, 32'd40);
      compared++;
      if ({count, top, next} !== {7'd5, 32'd40, 32'd30}) begin
         $display("[TB] FAIL push4 count=%0d top=%0d next=%0d want 5/40/30", count, top, next);
         mismatched++;
      end
      do_op(OP_SWAP, 32'd0);
      compared++;
      if ({count, top, next} !== {7'd5, 32'd30, 32'd40}) begin
         $display("[TB] FAIL swap count=%0d top=%0d next=%0d want 5/30/40", count, top, next);
         mismatched++;
      end
      do_op(OP_POP, 32'd0);
      compared++;
      if ({count, top, next} !== {7'd4, 32'd40, 32'd20}) begin
         $display("[TB] FAIL pop1 count=%0d top=%0d next=%0d want 4/40/20", count, top, next);
         mismatched++;
      end
      do_op(OP_POP, 32'd0);
      compared++;
      if ({count, top, next} !== {7'd3, 32'd20, 32'd10}) begin
         $display("[TB] FAIL pop2 count=%0d top=%0d next=%0d want 3/20/10", count, top, next);
         mismatched++;
      end
      do_op(OP_POP, 32'd0);
      compared++;
      if ({count, top, next} !== {7'd2, 32'd10, 32'd0}) begin
         $display("[TB] FAIL pop3 count=%0d top=%0d next=%0d want 2/10/0", count, top, next);
         mismatched++;
      end
      do_op(OP_POP, 32'd0);
      compared++;
      if ({count, top, next, error} !== {7'd1, 32'd0, 32'd0, 1'b0}) begin
         $display("[TB] FAIL pop_at2 count=%0d top=%0d next=%0d err=%b want 1/0/0/0",
                  count, top, next, error);
         mismatched++;
      end
   endtask

   task automatic test_idle();
      do_op(OP_PUSH_VALUE, 32'h1234);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         op_valid = 1'b0;
         op       = OP_CLEAR;
         value    = $urandom;
         @(negedge clock);
         compared++;
         if ({count, top, next, error} !== {7'd2, 32'h1234, 32'd0, 1'b0}) begin
            $display("[TB] FAIL idle_%0d count=%0d top=%0h next=%0h err=%b want 2/1234/0/0",
                     i, count, top, next, error);
            mismatched++;
         end
      end
      do_op(OP_WRITE, 32'hDEADBEEF);
      compared++;
      if ({count, top, next} !== {7'd2, 32'hDEADBEEF, 32'd0}) begin
         $display("[TB] FAIL write count=%0d top=%0h next=%0h want 2/deadbeef/0", count, top, next);
         mismatched++;
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clock);
      op_valid = 1'b1;
      op       = OP_PUSH_VALUE;
      value    = 32'hAA;
      @(negedge clock);
      compared++;
      if ({count, top, next} !== {7'd3, 32'hAA, 32'hDEADBEEF}) begin
         $display("[TB] FAIL b2b_push count=%0d top=%0h next=%0h want 3/aa/deadbeef", count, top, next);
         mismatched++;
      end
      op = OP_POP;
      @(negedge clock);
      op_valid = 1'b0;
      compared++;
      if ({count, top, next} !== {7'd2, 32'hDEADBEEF, 32'd0}) begin
         $display("[TB] FAIL b2b_pop count=%0d top=%0h next=%0h want 2/deadbeef/0", count, top, next);
         mismatched++;
      end
   endtask

   task automatic test_async_reset();
      do_op(OP_PUSH_VALUE, 32'd1);
      do_op(OP_PUSH_VALUE, 32'd2);
      do_op(OP_PUSH_VALUE, 32'd3);
      compared++;
      if (count !== 7'd5) begin
         $display("[TB] FAIL pre_reset count=%0d want 5", count);
         mismatched++;
      end
      #2;
      reset_n = 1'b0;
      #1;
      compared++;
      if ({count, top, next, overflow, underflow, error} !== {7'd1, 32'd0, 32'd0, 3'b000}) begin
         $display("[TB] FAIL midreset count=%0d top=%0h next=%0h flags=%b%b%b want 1/0/0/000",
                  count, top, next, overflow, underflow, error);
         mismatched++;
      end
      #1;
      reset_n = 1'b1;
      do_op(OP_PUSH_VALUE, 32'd9);
      compared++;
      if ({count, top, next} !== {7'd2, 32'd9, 32'd0}) begin
         $display("[TB] FAIL post_reset count=%0d top=%0h next=%0h want 2/9/0", count, top, next);
         mismatched++;
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset_n    = 1'b0;
      op_valid   = 1'b0;
      op         = OP_NOP;
      value      = '0;
      op_valid_s = 1'b0;
      op_s       = OP_NOP;
      value_s    = '0;
      test_reset();
      test_reduce();
      test_overflow();
      test_underflow();
      test_spill();
      test_idle();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/calc_stack.md
# calc_stack

Parametrised operand stack for the calculator datapath, successor to the fixed 32×64 stack. Holds between 1 and DEPTH entries of WIDTH bits, exposing the top two entries combinationally-free from registers. Adds one-cycle DUP/SWAP/REDUCE/CLEAR operations and separate sticky overflow/underflow flags. Sits between the input/keypad decoder (pushes and edits operands) and the ALU (consumes top/next, returns results via REDUCE).

## Interface
- WIDTH, 32, entry width in bits (≥1)
- DEPTH, 64, maximum entry count (≥3)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

- clock  in  1  single clock, all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  op is applied at this edge when high
- op  in  3  stack_op_t operation code
- value  in  WIDTH  data for WRITE, PUSH_VALUE, REDUCE
- top  out  WIDTH  entry at top of stack
- next  out  WIDTH  entry below top; 0 when count==1
- count  out  CW  number of entries, range 1..DEPTH
- overflow  out  1  sticky: push attempted at count==DEPTH
- underflow  out  1  sticky: removal attempted with too few entries
- error  out  1  overflow | underflow

## Operation
- Stack always holds ≥1 entry; logically empty calculator = count 1, top 0.
- Ops (accepted only when op_valid=1 and error=0, except CLEAR):
  - 0 NOP: no change.
  - 1 PUSH: count+1, new top=0, old top becomes next. Overflow if count==DEPTH.
  - 2 POP: count−1, next becomes top. Underflow if count==1.
  - 3 WRITE: top←value; count unchanged.
  - 4 PUSH_VALUE: as PUSH but new top=value.
  - 5 REDUCE: remove top and next, push value (net count−1; binary ALU result). Underflow if count<2.
  - 6 SWAP: exchange top and next. Underflow if count<2.
  - 7 CLEAR: count=1, top=0, next=0, both flags cleared. Always accepted, even with error set.
- Failing op: no change to count/top/next/memory; corresponding flag set.
- While error=1, every op except CLEAR is ignored (no state change, flags unchanged).
- DUP is PUSH_VALUE with value=top; no separate code.
- Storage: top and next in registers; entries 3..DEPTH in spill RAM indexed by count−3. PUSH-type ops: next→RAM[count−2], top→next. POP-type ops: next→top (POP) and RAM[count−3]→next; when count drops to 1, next←0.
- next output is 0 whenever count==1 regardless of register content.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert handled upstream): count=1, top=0, next=0, overflow=0, underflow=0, error=0. Reset mid-operation discards the op in flight; spill RAM contents undefined, unobservable.
- Latency 1: op sampled at edge N, outputs reflect it immediately after edge N. All outputs are registered or decode of registers only; no input→output combinational path.
- No back-pressure; one op per cycle, back-to-back ops allowed (e.g. PUSH then POP on consecutive edges returns to original state).
- Spill RAM: synchronous write, asynchronous read, so POP/REDUCE refill next in the same cycle.
- Boundaries: PUSH at count DEPTH−1 succeeds (count=DEPTH); at DEPTH sets overflow. POP at count 2 gives count 1, next 0. REDUCE at count 2 gives count 1, top=value.

## Structure
- Package calc_pkg: stack_op_t enum (NOP..CLEAR, 3 bits) and op encodings; shared with the decoder and ALU control.
- Sub-module stack_spill_ram: (DEPTH−2)×WIDTH, sync write, async read, no reset.
- calc_stack holds control, pointer, top/next registers and flags.

## Test plan
- Reset then PUSH_VALUE 5, PUSH_VALUE 7 → top=7, next=5, count=3; REDUCE value=12 → top=12, next=0, count=2... (count=1 after second REDUCE from 2 entries), next=0.
- WIDTH=8, DEPTH=4: PUSH_VALUE 1,2,3 → count=4; PUSH_VALUE 4 → overflow=1, error=1, top=3, count=4; POP ignored; CLEAR → count=1, top=0, flags 0.
- Reset, POP → underflow=1, count=1, top=0; SWAP at count 1 after CLEAR → underflow=1, top unchanged.
- PUSH_VALUE 10,20,30,40 (DEPTH=64), SWAP → top=30, next=40; POP ×3 → top=10 at count 2... then count=1, next=0; values from spill RAM returned in order.
- op_valid=0 with op=CLEAR and random value for 10 cycles → no output change; WRITE 0xDEADBEEF → top=0xDEADBEEF, count unchanged.
- Assert reset_n low between edges mid-sequence at count 5 → all outputs reset immediately without a clock edge; next PUSH_VALUE 9 → count=2, top=9, next=0.
